state_if: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32 pipeline; sits directly upstream of the decode stage.
- Drives the instruction-memory request/response handshake and holds the PC.
- Delivers each fetched instruction and its PC to decode with a complete_this strobe.
- Honours branch/jump redirects from execute and memory-stage backpressure.

---
 rtl/state_if.sv | 118 +++++++++++
 tb/tb_state_if.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/state_if.sv
// rtl/state_if.sv - RV32 instruction-fetch stage: imem handshake, PC, redirect and stall handling
module state_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC,
    output logic        Inst_Req_Valid,
    input  logic        Inst_Req_Ready,
    input  logic [31:0] Instruction,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic        fb_ex_branch,
    input  logic [31:0] branch_PC,
    input  logic        fb_mem,
    output logic        complete_this,
    output logic [31:0] PC_output,
    output logic [31:0] Instruction_reg,
    output logic [31:0] cpu_perf_cnt_0,
    output logic [31:0] cpu_perf_cnt_2
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_DONE = 2'd3
    } state_t;

    state_t state;
    // kill marks an outstanding request whose response belongs to a squashed path
    logic   kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= INIT;
            PC              <= RESET_PC;
            kill            <= 1'b0;
            Inst_Req_Valid  <= 1'b0;
            Inst_Ready      <= 1'b0;
            complete_this   <= 1'b0;
            PC_output       <= 32'h0;
            Instruction_reg <= 32'h0;
            cpu_perf_cnt_0  <= 32'h0;
            cpu_perf_cnt_2  <= 32'h0;
        end else begin
            if (state == IF_REQ || state == IF_WAIT) begin
                cpu_perf_cnt_2 <= cpu_perf_cnt_2 + 32'd1;
            end

            case (state)
                INIT: begin
                    state          <= IF_REQ;
                    Inst_Req_Valid <= 1'b1;
                end

                IF_REQ: begin
                    if (Inst_Req_Ready) begin
                        state          <= IF_WAIT;
                        Inst_Req_Valid <= 1'b0;
                        Inst_Ready     <= 1'b1;
                        // The old-PC request is already on its way; its data must be dropped
                        if (fb_ex_branch) begin
                            PC   <= branch_PC;
                            kill <= 1'b1;
                        end
                    end else if (fb_ex_branch) begin
                        PC <= branch_PC;
                    end
                end

                IF_WAIT: begin
                    if (Inst_Valid) begin
                        Inst_Ready <= 1'b0;
                        if (kill || fb_ex_branch) begin
                            kill           <= 1'b0;
                            state          <= IF_REQ;
                            Inst_Req_Valid <= 1'b1;
                            if (fb_ex_branch) begin
                                PC <= branch_PC;
                            end
                        end else begin
                            Instruction_reg <= Instruction;
                            PC_output       <= PC;
                            PC              <= PC + 32'd4;
                            complete_this   <= 1'b1;
                            state           <= IF_DONE;
                        end
                    end else if (fb_ex_branch) begin
                        PC   <= branch_PC;
                        kill <= 1'b1;
                    end
                end

                IF_DONE: begin
                    if (fb_ex_branch) begin
                        complete_this  <= 1'b0;
                        PC             <= branch_PC;
                        state          <= IF_REQ;
                        Inst_Req_Valid <= 1'b1;
                    end else if (!fb_mem) begin
                        complete_this  <= 1'b0;
                        cpu_perf_cnt_0 <= cpu_perf_cnt_0 + 32'd1;
                        state          <= IF_REQ;
                        Inst_Req_Valid <= 1'b1;
                    end
                end

                default: begin
                    state          <= INIT;
                    Inst_Req_Valid <= 1'b0;
                    Inst_Ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_if.sv
// tb/tb_state_if.sv - randomized bench for state_if against a transaction-level fetch model
module tb_state_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready = 1'b0;
    logic [31:0] Instruction = 32'h0;
    logic        Inst_Valid = 1'b0;
    logic        Inst_Ready;
    logic        fb_ex_branch = 1'b0;
    logic [31:0] branch_PC = 32'h0;
    logic        fb_mem = 1'b0;
    logic        complete_this;
    logic [31:0] PC_output;
    logic [31:0] Instruction_reg;
    logic [31:0] cpu_perf_cnt_0;
    logic [31:0] cpu_perf_cnt_2;

    state_if #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .PC             (PC),
        .Inst_Req_Valid (Inst_Req_Valid),
        .Inst_Req_Ready (Inst_Req_Ready),
        .Instruction    (Instruction),
        .Inst_Valid     (Inst_Valid),
        .Inst_Ready     (Inst_Ready),
        .fb_ex_branch   (fb_ex_branch),
        .branch_PC      (branch_PC),
        .fb_mem         (fb_mem),
        .complete_this  (complete_this),
        .PC_output      (PC_output),
        .Instruction_reg(Instruction_reg),
        .cpu_perf_cnt_0 (cpu_perf_cnt_0),
        .cpu_perf_cnt_2 (cpu_perf_cnt_2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs (percentages) and memory latency bound
    int p_rdy = 100, p_br = 0, p_fbm = 0, p_spur = 0, max_delay = 0;

    // Reference model: fetch-stage phase flags, PCs and counters
    logic        m_boot, m_asking, m_awaiting, m_holding, m_doomed;
    logic [31:0] m_pc, m_out_pc, m_out_inst, m_cnt0, m_cnt2;

    // Instruction memory: one outstanding request, fixed content per address
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot     = 1'b1;
        m_asking   = 1'b0;
        m_awaiting = 1'b0;
        m_holding  = 1'b0;
        m_doomed   = 1'b0;
        m_pc       = RESET_PC;
        m_out_pc   = 32'h0;
        m_out_inst = 32'h0;
        m_cnt0     = 32'h0;
        m_cnt2     = 32'h0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        mem_addr   = 32'h0;
    endtask

    task automatic model_step(input logic rdy, input logic iv, input logic [31:0] ins,
                              input logic br, input logic [31:0] bpc, input logic fbm);
        if (m_asking || m_awaiting) m_cnt2 = m_cnt2 + 32'd1;
        if (m_boot) begin
            m_boot   = 1'b0;
            m_asking = 1'b1;
        end else if (m_asking) begin
            if (br) m_pc = bpc;
            if (rdy) begin
                m_asking   = 1'b0;
                m_awaiting = 1'b1;
                m_doomed   = br;
            end
        end else if (m_awaiting) begin
            if (iv) begin
                m_awaiting = 1'b0;
                if (m_doomed || br) begin
                    if (br) m_pc = bpc;
                    m_doomed = 1'b0;
                    m_asking = 1'b1;
                end else begin
                    m_out_inst = ins;
                    m_out_pc   = m_pc;
                    m_pc       = m_pc + 32'd4;
                    m_holding  = 1'b1;
                end
            end else if (br) begin
                m_pc     = bpc;
                m_doomed = 1'b1;
            end
        end else if (m_holding) begin
            if (br) begin
                m_pc      = bpc;
                m_holding = 1'b0;
                m_asking  = 1'b1;
            end else if (!fbm) begin
                m_cnt0    = m_cnt0 + 32'd1;
                m_holding = 1'b0;
                m_asking  = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("pc", PC, m_pc);
        check("req_valid", 32'(Inst_Req_Valid), 32'(m_asking));
        check("inst_ready", 32'(Inst_Ready), 32'(m_awaiting));
        check("complete", 32'(complete_this), 32'(m_holding));
        check("pc_output", PC_output, m_out_pc);
        check("instr_reg", Instruction_reg, m_out_inst);
        check("perf_cnt0", cpu_perf_cnt_0, m_cnt0);
        check("perf_cnt2", cpu_perf_cnt_2, m_cnt2);
    endtask

    task automatic tick();
        logic        rdy, br, fbm, iv;
        logic [31:0] bpc, ins;
        rdy = ($urandom_range(99) < p_rdy);
        br  = ($urandom_range(99) < p_br);
        fbm = ($urandom_range(99) < p_fbm);
        bpc = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        if (mem_busy) begin
            iv  = (mem_cnt == 0);
            ins = mem_word(mem_addr);
        end else begin
            iv  = ($urandom_range(99) < p_spur);
            ins = $urandom;
        end
        Inst_Req_Ready = rdy;
        fb_ex_branch   = br;
        branch_PC      = bpc;
        fb_mem         = fbm;
        Inst_Valid     = iv;
        Instruction    = ins;
        @(posedge clk);
        if (mem_busy) begin
            if (iv) mem_busy = 1'b0;
            else    mem_cnt--;
        end else if (m_asking && rdy) begin
            mem_busy = 1'b1;
            mem_addr = m_pc;
            mem_cnt  = $urandom_range(max_delay);
        end
        model_step(rdy, iv, ins, br, bpc, fbm);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_knobs(input int rdy, input int br, input int fbm, input int spur, input int dly);
        p_rdy = rdy; p_br = br; p_fbm = fbm; p_spur = spur; max_delay = dly;
    endtask

    initial begin
        int guard;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait memory, no redirects: one instruction per three cycles
        set_knobs(100, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            check("zw_complete", 32'(complete_this), 32'd1);
            check("zw_pc_output", PC_output, 32'(4 * k));
            check("zw_instr", Instruction_reg, mem_word(32'(4 * k)));
            tick();
            check("zw_cnt0", cpu_perf_cnt_0, 32'(k + 1));
        end

        // Randomized mixes of backpressure, redirects, latency and stray responses
        set_knobs(30, 0, 60, 30, 3);
        for (int i = 0; i < 600; i++) tick();
        set_knobs(60, 25, 40, 20, 4);
        for (int i = 0; i < 1200; i++) tick();
        set_knobs(100, 50, 20, 50, 0);
        for (int i = 0; i < 600; i++) tick();
        set_knobs(50, 10, 50, 10, 5);
        for (int i = 0; i < 600; i++) tick();

        // Asynchronous reset while a response is outstanding
        set_knobs(100, 0, 0, 0, 8);
        guard = 0;
        while (!(m_awaiting && mem_busy && mem_cnt > 1) && guard < 40) begin
            tick();
            guard++;
        end
        check("reach_wait", 32'(guard < 40), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_pc", PC, RESET_PC);
        check("rst_req_valid", 32'(Inst_Req_Valid), 32'd0);
        check("rst_inst_ready", 32'(Inst_Ready), 32'd0);
        check("rst_complete", 32'(complete_this), 32'd0);
        check("rst_pc_output", PC_output, 32'h0);
        check("rst_instr_reg", Instruction_reg, 32'h0);
        check("rst_cnt0", cpu_perf_cnt_0, 32'h0);
        check("rst_cnt2", cpu_perf_cnt_2, 32'h0);
        Inst_Valid  = 1'b1;
        Instruction = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Inst_Valid = 1'b0;
        model_reset();
        rst = 1'b1;
        set_knobs(70, 10, 30, 20, 2);
        for (int i = 0; i < 200; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
